// File: rtl/mult_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
package mult_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DIGIT_WIDTH = 2;
  localparam int unsigned PROD_WIDTH  = 4;

  typedef struct packed {
    logic [15:0] digits;
    logic [15:0] idx_width;
  } digit_cfg_t;

  // Digits per operand and the index width needed to walk them (at least 1 bit).
  function automatic digit_cfg_t digit_cfg(input int unsigned data_width);
    digit_cfg_t cfg;
    cfg.digits    = 16'(data_width / DIGIT_WIDTH);
    cfg.idx_width = (cfg.digits > 16'd1) ? 16'($clog2(cfg.digits)) : 16'd1;
    return cfg;
  endfunction

endpackage

// File: rtl/multiplier_digit_serial_if.sv
// Request/result bundle for the digit-serial multiplier.
interface multiplier_digit_serial_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                    Start_In;
  logic [DATA_WIDTH-1:0]   Data_A_In;
  logic [DATA_WIDTH-1:0]   Data_B_In;
  logic                    Busy_Out;
  logic                    Done_Out;
  logic [2*DATA_WIDTH-1:0] Multiplied_Result_Out;

  modport master (
    output Start_In, Data_A_In, Data_B_In,
    input  Busy_Out, Done_Out, Multiplied_Result_Out
  );

  modport slave (
    input  Start_In, Data_A_In, Data_B_In,
    output Busy_Out, Done_Out, Multiplied_Result_Out
  );

endinterface

// File: rtl/multiplier_digit_serial_digit_product.sv
// Combinational 2x2-bit unsigned digit product.
module digit_product_2x2
  import mult_serial_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] a,
  input  logic [DIGIT_WIDTH-1:0] b,
  output logic [PROD_WIDTH-1:0]  prod_c
);

  assign prod_c = PROD_WIDTH'(a) * PROD_WIDTH'(b);

endmodule

// File: rtl/multiplier_digit_serial.sv
// Digit-serial unsigned NxN multiplier, one 2x2 digit product per cycle.
// Define MULT_SERIAL_ZERO_SKIP_EN to finish immediately on a zero operand.
module multiplier_digit_serial
  import mult_serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                      Clock_In,
  input logic                      Reset_n_In,
  multiplier_digit_serial_if.slave bus
);

  localparam digit_cfg_t  CFG  = digit_cfg(DATA_WIDTH);
  localparam int unsigned D    = 32'(CFG.digits);
  localparam int unsigned IW   = 32'(CFG.idx_width);
  localparam int unsigned PW   = 2 * DATA_WIDTH;
  localparam int unsigned SW   = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]         i_q, j_q;
  logic [PW-1:0]         acc_q, result_q;
  logic                  busy_q, done_q;
  logic                  busy_d, done_d;

  logic [DIGIT_WIDTH-1:0] a_dig, b_dig;
  logic [PROD_WIDTH-1:0]  prod_c;
  logic [SW-1:0]          shamt;
  logic [PW-1:0]          term, acc_sum;
  logic                   last_step;

`ifdef MULT_SERIAL_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (bus.Data_A_In == '0) || (bus.Data_B_In == '0);
`endif

  // Select the current digit pair and place its product at weight 4^(i+j).
  assign a_dig     = DIGIT_WIDTH'(a_q >> {i_q, 1'b0});
  assign b_dig     = DIGIT_WIDTH'(b_q >> {j_q, 1'b0});
  assign shamt     = SW'((SW'(i_q) + SW'(j_q)) << 1);
  assign term      = PW'(prod_c) << shamt;
  assign acc_sum   = acc_q + term;
  assign last_step = (i_q == LAST) && (j_q == LAST);

  digit_product_2x2 u_digit_product (
    .a      (a_dig),
    .b      (b_dig),
    .prod_c (prod_c)
  );

  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.Start_In) begin
`ifdef MULT_SERIAL_ZERO_SKIP_EN
          next_state = zero_op ? DONE : RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN:     if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start_In) begin
            a_q   <= bus.Data_A_In;
            b_q   <= bus.Data_B_In;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
`ifdef MULT_SERIAL_ZERO_SKIP_EN
            if (zero_op) result_q <= '0;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_sum;
          if (i_q == LAST) begin
            i_q <= '0;
            j_q <= last_step ? '0 : j_q + IW'(1);
          end else begin
            i_q <= i_q + IW'(1);
          end
          if (last_step) result_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy_Out              = busy_q;
  assign bus.Done_Out              = done_q;
  assign bus.Multiplied_Result_Out = result_q;

endmodule

// File: tb/tb_multiplier_digit_serial.sv
// Scoreboard bench for multiplier_digit_serial at DATA_WIDTH 8 and 4.
module tb_multiplier_digit_serial;

  localparam int unsigned W8 = 8;
  localparam int unsigned W4 = 4;
`ifdef MULT_SERIAL_ZERO_SKIP_EN
  localparam int ZERO_DONE_K = 1;
  localparam int ZERO_BUSY   = 1;
`else
  localparam int ZERO_DONE_K = 17;
  localparam int ZERO_BUSY   = 17;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_digit_serial_if #(.DATA_WIDTH(W8)) bus8 ();
  multiplier_digit_serial_if #(.DATA_WIDTH(W4)) bus4 ();

  multiplier_digit_serial #(.DATA_WIDTH(W8)) dut8 (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .bus        (bus8)
  );

  multiplier_digit_serial #(.DATA_WIDTH(W4)) dut4 (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .bus        (bus4)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];
  int unsigned rises[$];
  logic        busy8_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every Done pulse retires the oldest expected product.
  always @(negedge clk) begin
    if (bus8.Done_Out === 1'b1) begin
      if (sb8.size() == 0) check("done8_unexpected", 32'(bus8.Done_Out), 32'd0);
      else check("result8", 32'(bus8.Multiplied_Result_Out), 32'(sb8.pop_front()));
    end
    if (bus4.Done_Out === 1'b1) begin
      if (sb4.size() == 0) check("done4_unexpected", 32'(bus4.Done_Out), 32'd0);
      else check("result4", 32'(bus4.Multiplied_Result_Out), 32'(sb4.pop_front()));
    end
    if (bus8.Busy_Out === 1'b1 && !busy8_prev) rises.push_back(cyc);
    busy8_prev = (bus8.Busy_Out === 1'b1);
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit expect_result);
    bus8.Start_In  = 1'b1;
    bus8.Data_A_In = a;
    bus8.Data_B_In = b;
    if (expect_result) sb8.push_back(16'(a) * 16'(b));
    @(posedge clk);
    #1;
    bus8.Start_In  = 1'b0;
    bus8.Data_A_In = ~a;
    bus8.Data_B_In = b ^ 8'h5A;
  endtask

  // Called just after the accepting edge; k counts the cycles that follow it.
  task automatic wait8(input int glitch_k, output int done_at, output int busy_cyc, output int done_cnt);
    done_at  = 0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus8.Busy_Out === 1'b1) busy_cyc++;
      if (bus8.Done_Out === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == glitch_k) begin
        bus8.Start_In  = 1'b1;
        bus8.Data_A_In = 8'd2;
        bus8.Data_B_In = 8'd3;
      end else if (k == glitch_k + 1) begin
        bus8.Start_In = 1'b0;
      end
      if (bus8.Busy_Out !== 1'b1) break;
      if (k == 60) check("timeout8", 32'(bus8.Busy_Out), 32'd0);
    end
  endtask

  initial begin
    int da, bc, dc;
    logic [3:0] a4;
    bus8.Start_In = 1'b0; bus8.Data_A_In = '0; bus8.Data_B_In = '0;
    bus4.Start_In = 1'b0; bus4.Data_A_In = '0; bus4.Data_B_In = '0;

    // Reset held with a pending request.
    rst_n = 1'b0;
    bus8.Start_In = 1'b1; bus8.Data_A_In = 8'hFF; bus8.Data_B_In = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", 32'(bus8.Busy_Out), 32'd0);
      check("rst_done", 32'(bus8.Done_Out), 32'd0);
      check("rst_result", 32'(bus8.Multiplied_Result_Out), 32'd0);
    end
    bus8.Start_In = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_capture", 32'(bus8.Busy_Out), 32'd0);

    // Max operands.
    issue8(8'hFF, 8'hFF, 1'b1);
    wait8(-10, da, bc, dc);
    check("max_latency", 32'(da - 1), 32'd16);
    check("max_busy", 32'(bc), 32'd17);
    check("max_done_pulses", 32'(dc), 32'd1);

    // Start pulsed mid-run is ignored.
    issue8(8'd13, 8'd11, 1'b1);
    wait8(5, da, bc, dc);
    check("ign_latency", 32'(da - 1), 32'd16);
    check("ign_done_pulses", 32'(dc), 32'd1);
    repeat (4) @(negedge clk);
    check("ign_idle", 32'(bus8.Busy_Out), 32'd0);

    // Zero operand.
    issue8(8'd0, 8'hA5, 1'b1);
    wait8(-10, da, bc, dc);
    check("zero_done_at", 32'(da), 32'(ZERO_DONE_K));
    check("zero_busy", 32'(bc), 32'(ZERO_BUSY));

    // Back-to-back with Start held high.
    rises.delete();
    bus8.Start_In = 1'b1; bus8.Data_A_In = 8'd200; bus8.Data_B_In = 8'd100;
    sb8.push_back(16'd20000);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus8.Done_Out === 1'b1) begin
        bus8.Data_A_In = 8'd7;
        bus8.Data_B_In = 8'd9;
        sb8.push_back(16'd63);
      end
      if (bus8.Busy_Out !== 1'b1) break;
      if (k == 60) check("timeout_b2b", 32'(bus8.Busy_Out), 32'd0);
    end
    @(posedge clk);
    #1;
    bus8.Start_In = 1'b0;
    wait8(-10, da, bc, dc);
    check("b2b_latency2", 32'(da - 1), 32'd16);
    check("b2b_accepts", 32'(rises.size()), 32'd2);
    if (rises.size() == 2) check("b2b_interval", 32'(rises[1] - rises[0]), 32'd18);

    // Reset in the middle of a run.
    issue8(8'd200, 8'd100, 1'b0);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    check("midrst_busy_before", 32'(bus8.Busy_Out), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus8.Busy_Out), 32'd0);
    check("midrst_done", 32'(bus8.Done_Out), 32'd0);
    check("midrst_result", 32'(bus8.Multiplied_Result_Out), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_idle", 32'(bus8.Busy_Out), 32'd0);
    issue8(8'd3, 8'd7, 1'b1);
    wait8(-10, da, bc, dc);
    check("post_rst_latency", 32'(da - 1), 32'd16);

    // Narrow instance.
    a4 = 4'hF;
    bus4.Start_In = 1'b1; bus4.Data_A_In = a4; bus4.Data_B_In = a4;
    sb4.push_back(8'(a4) * 8'(a4));
    @(posedge clk);
    #1;
    bus4.Start_In = 1'b0; bus4.Data_A_In = 4'h3; bus4.Data_B_In = 4'h1;
    da = 0; bc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus4.Busy_Out === 1'b1) bc++;
      if (bus4.Done_Out === 1'b1 && da == 0) da = k;
      if (bus4.Busy_Out !== 1'b1) break;
      if (k == 30) check("timeout4", 32'(bus4.Busy_Out), 32'd0);
    end
    check("w4_latency", 32'(da - 1), 32'd4);
    check("w4_busy", 32'(bc), 32'd5);

    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb4_drained", 32'(sb4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
